// File: rtl/pdp1_mem_sequencer_pkg.sv
// PDP-1 opcode encodings (instruction bits 0-4) shared across the CPU, plus the
// memory-access class of each op used by the memory sequencer.
`ifndef PDP1_OPCODES_DEFINED
`define PDP1_OPCODES_DEFINED
`define PDP1_OP_AND 5'o01
`define PDP1_OP_IOR 5'o02
`define PDP1_OP_XOR 5'o03
`define PDP1_OP_XCT 5'o04
`define PDP1_OP_CAL 5'o07
`define PDP1_OP_LAC 5'o10
`define PDP1_OP_LIO 5'o11
`define PDP1_OP_DAC 5'o12
`define PDP1_OP_DAP 5'o13
`define PDP1_OP_DIP 5'o14
`define PDP1_OP_DIO 5'o15
`define PDP1_OP_DZM 5'o16
`define PDP1_OP_ADD 5'o20
`define PDP1_OP_SUB 5'o21
`define PDP1_OP_IDX 5'o22
`define PDP1_OP_ISP 5'o23
`define PDP1_OP_SAD 5'o24
`define PDP1_OP_SAS 5'o25
`define PDP1_OP_MUL 5'o26
`define PDP1_OP_DIV 5'o27
`define PDP1_OP_JMP 5'o30
`define PDP1_OP_JSP 5'o31
`endif

package pdp1_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    OPC_READ  = 2'd0,
    OPC_WRITE = 2'd1,
    OPC_RMW   = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [0:4] op);
    op_class_e c;
    case (op)
      `PDP1_OP_DAP, `PDP1_OP_DIP:                             c = OPC_RMW;
      `PDP1_OP_CAL, `PDP1_OP_DAC, `PDP1_OP_DIO, `PDP1_OP_DZM: c = OPC_WRITE;
      default:                                                c = OPC_READ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pdp1_write_decoder.sv
// Builds the memory write word for an op from AC, IO and the current core word.
// Purely combinational; we_o=0 for ops that never store.
module pdp1_write_decoder (
  input  logic [0:4]  op_i,
  input  logic [0:17] ac_i,
  input  logic [0:17] io_i,
  input  logic [0:17] cd_i,
  output logic        we_o,
  output logic [0:17] wdata_o
);

  always_comb begin
    we_o    = 1'b0;
    wdata_o = '0;
    case (op_i)
      `PDP1_OP_CAL, `PDP1_OP_DAC: begin
        we_o    = 1'b1;
        wdata_o = ac_i;
      end
      `PDP1_OP_DIO: begin
        we_o    = 1'b1;
        wdata_o = io_i;
      end
      `PDP1_OP_DZM: begin
        we_o    = 1'b1;
      end
      // DAP replaces the address field, DIP the instruction field
      `PDP1_OP_DAP: begin
        we_o    = 1'b1;
        wdata_o = {cd_i[0:5], ac_i[6:17]};
      end
      `PDP1_OP_DIP: begin
        we_o    = 1'b1;
        wdata_o = {ac_i[0:5], cd_i[6:17]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pdp1_mem_sequencer.sv
// Runs one PDP-1 memory-reference cycle (read, write, or read-merge-write) on the core bus.
// Done 3 cycles after start (6 for DAP/DIP) with zero-wait ack; stalls on mem_ack up to TIMEOUT.
module pdp1_mem_sequencer
  import pdp1_mem_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_start,
  input  logic [0:4]        cs_op,
  input  logic [0:ADDR_W-1] cs_addr,
  input  logic [0:17]       cs_ac,
  input  logic [0:17]       cs_io,
  output logic              cs_busy,
  output logic              cs_done,
  output logic              cs_err,
  output logic [0:17]       cs_md,
  output logic              mem_req,
  output logic              mem_we,
  output logic [0:ADDR_W-1] mem_addr,
  output logic [0:17]       mem_wdata,
  input  logic              mem_ack,
  input  logic [0:17]       mem_rdata
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [0:4]        op_q;
  logic [0:17]       ac_q, io_q, cd_q, md_q, wdata_q;
  logic [0:ADDR_W-1] addr_q;
  logic              busy_q, done_q, err_q, req_q, we_q;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic              idle;
  logic [0:4]        dec_op;
  logic [0:17]       dec_ac, dec_io, dec_cd, dec_wdata;
  logic              dec_we;
  logic              tmo;

  // Write-only ops take their data on the start edge, before the latches hold it
  assign idle   = (state_q == S_IDLE);
  assign dec_op = idle ? cs_op : op_q;
  assign dec_ac = idle ? cs_ac : ac_q;
  assign dec_io = idle ? cs_io : io_q;
  assign dec_cd = idle ? '0    : cd_q;

  pdp1_write_decoder u_wdec (
    .op_i    (dec_op),
    .ac_i    (dec_ac),
    .io_i    (dec_io),
    .cd_i    (dec_cd),
    .we_o    (dec_we),
    .wdata_o (dec_wdata)
  );

  assign tcnt_d = tcnt_q + 1'b1;
  assign tmo    = (TIMEOUT != 0) && req_q && !mem_ack && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ac_q    <= '0;
      io_q    <= '0;
      cd_q    <= '0;
      md_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (req_q && !mem_ack) tcnt_q <= tcnt_d;

      if (tmo) begin
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_start) begin
              op_q   <= cs_op;
              ac_q   <= cs_ac;
              io_q   <= cs_io;
              addr_q <= cs_addr;
              busy_q <= 1'b1;
              req_q  <= 1'b1;
              tcnt_q <= '0;
              if (op_class(cs_op) == OPC_WRITE) begin
                we_q    <= 1'b1;
                wdata_q <= dec_wdata;
                state_q <= S_WR;
              end else begin
                we_q    <= 1'b0;
                state_q <= S_RD;
              end
            end
          end
          S_RD: begin
            if (req_q && mem_ack) begin
              req_q   <= 1'b0;
              md_q    <= mem_rdata;
              cd_q    <= mem_rdata;
              state_q <= (op_class(op_q) == OPC_RMW) ? S_MERGE : S_DONE;
            end
          end
          S_MERGE: begin
            wdata_q <= dec_wdata;
            state_q <= dec_we ? S_WR : S_DONE;
          end
          S_WR: begin
            // Coming from MERGE the request is raised here, leaving a req-low gap
            if (!req_q) begin
              req_q  <= 1'b1;
              we_q   <= 1'b1;
              tcnt_q <= '0;
            end else if (mem_ack) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cs_busy   = busy_q;
  assign cs_done   = done_q;
  assign cs_err    = err_q;
  assign cs_md     = md_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
